// File: rtl/cp0_irq_ctrl_pkg.sv
// Shared CP0 definitions: register map, oper encodings, field positions, FSM states.
package cp0_irq_ctrl_pkg;

  localparam logic [4:0] ADDR_STATUS = 5'd12;
  localparam logic [4:0] ADDR_CAUSE  = 5'd13;
  localparam logic [4:0] ADDR_EPC    = 5'd14;
  localparam logic [4:0] ADDR_VBASE  = 5'd15;
  localparam logic [4:0] ADDR_MODE   = 5'd16;

  typedef enum logic [1:0] {
    OPER_NONE = 2'b00,
    OPER_MFC0 = 2'b01,
    OPER_MTC0 = 2'b10,
    OPER_ERET = 2'b11
  } oper_e;

  localparam int STATUS_IE     = 0;
  localparam int STATUS_EXL    = 1;
  localparam int STATUS_IM_LSB = 8;
  localparam int CAUSE_IP_LSB  = 8;
  localparam int CAUSE_ID_LSB  = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_JUMP    = 3'd2,
    ST_SERVICE = 3'd3,
    ST_RET     = 3'd4
  } state_e;

  // Fixed-priority select: lowest set index wins.
  function automatic logic [3:0] prio_enc(input logic [15:0] v);
    logic [3:0] r;
    r = '0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) r = 4'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/cp0_irq_ctrl_irq_sync_edge.sv
// Per-channel synchroniser for an asynchronous interrupt line, with rise detect.
module cp0_irq_ctrl_irq_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic ir_in,
  output logic level,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;

  // Shift the raw line through the synchroniser and keep one cycle of history.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], ir_in};
      prev <= sync[SYNC_STAGES-1];
    end
  end

  assign level = sync[SYNC_STAGES-1];
  assign rise  = level & ~prev;

endmodule

// File: rtl/cp0_irq_ctrl.sv
// Vectored interrupt controller with CP0 register file.
//
// state   | meaning
// IDLE    | no request, waiting for IE & ~EXL & pending&mask
// REQ     | request seen, waiting for pipeline to accept redirect
// JUMP    | jump_en pulse to channel vector
// SERVICE | handler running (EXL=1), waiting for ERET
// RET     | jump_en pulse back to EPC, EXL cleared on exit
module cp0_irq_ctrl
  import cp0_irq_ctrl_pkg::*;
#(
  parameter int          N_IRQ       = 4,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] VEC_BASE    = 32'h0000_0010,
  parameter int          VEC_STRIDE  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       oper,
  input  logic [4:0]       addr_r,
  output logic [31:0]      data_r,
  input  logic [4:0]       addr_w,
  input  logic [31:0]      data_w,
  input  logic [N_IRQ-1:0] ir_in,
  input  logic             ir_en,
  input  logic [31:0]      ret_addr,
  output logic             jump_en,
  output logic [31:0]      jump_addr,
  output logic             irq_busy
);

  logic             ie, exl;
  logic [N_IRQ-1:0] im, ip, mode;
  logic [4:0]       cause_id;
  logic [31:0]      epc, vbase;
  state_e           state;

  logic [N_IRQ-1:0] level, rise, pend, clr;
  logic [15:0]      pend_ext;
  logic [3:0]       ch;
  logic             req, take, wr, eret;

  for (genvar i = 0; i < N_IRQ; i++) begin : g_sync
    cp0_irq_ctrl_irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .rst   (rst),
      .ir_in (ir_in[i]),
      .level (level[i]),
      .rise  (rise[i])
    );
  end

  // Request qualification and priority select.
  always_comb begin
    pend_ext            = '0;
    pend                = ip & im;
    pend_ext[N_IRQ-1:0] = pend;
    req                 = ie & ~exl & (|pend);
    ch                  = prio_enc(pend_ext);
    take                = (state == ST_REQ) & req & ir_en;
    clr                 = take ? (N_IRQ'(1) << ch) : '0;
    wr                  = (oper == OPER_MTC0);
    eret                = (oper == OPER_ERET);
  end

  // Register file writes; entry side effects take precedence over MTC0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ie       <= 1'b0;
      exl      <= 1'b0;
      im       <= '0;
      cause_id <= '0;
      epc      <= '0;
      vbase    <= VEC_BASE;
      mode     <= '0;
    end else begin
      if (wr && addr_w == ADDR_STATUS) begin
        ie <= data_w[STATUS_IE];
        im <= data_w[STATUS_IM_LSB +: N_IRQ];
      end
      if (wr && addr_w == ADDR_VBASE) vbase <= {data_w[31:2], 2'b00};
      if (wr && addr_w == ADDR_MODE)  mode  <= data_w[N_IRQ-1:0];
      if (take) begin
        exl      <= 1'b1;
        epc      <= ret_addr;
        cause_id <= {1'b0, ch};
      end else begin
        if (state == ST_RET) exl <= 1'b0;
        if (wr && addr_w == ADDR_EPC) epc <= data_w;
      end
    end
  end

  // Pending bits: level channels track the line; edge channels latch a rise
  // until taken, and a rise in the clearing cycle wins so it is not lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ip <= '0;
    else      ip <= (mode & level) | (~mode & (rise | (ip & ~clr)));
  end

  // Sequencer with registered jump outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      jump_en   <= 1'b0;
      jump_addr <= '0;
    end else begin
      jump_en <= 1'b0;
      case (state)
        ST_IDLE: if (req) state <= ST_REQ;
        ST_REQ: begin
          if (!req) begin
            state <= ST_IDLE;
          end else if (ir_en) begin
            state     <= ST_JUMP;
            jump_en   <= 1'b1;
            jump_addr <= vbase + 32'(ch) * 32'(VEC_STRIDE);
          end
        end
        ST_JUMP: state <= ST_SERVICE;
        ST_SERVICE: begin
          if (eret) begin
            state     <= ST_RET;
            jump_en   <= 1'b1;
            jump_addr <= epc;
          end
        end
        ST_RET:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign irq_busy = exl;

  // Combinational read port.
  always_comb begin
    data_r = '0;
    case (addr_r)
      ADDR_STATUS: begin
        data_r[STATUS_IE]                   = ie;
        data_r[STATUS_EXL]                  = exl;
        data_r[STATUS_IM_LSB +: N_IRQ]      = im;
      end
      ADDR_CAUSE: begin
        data_r[CAUSE_IP_LSB +: N_IRQ]       = ip;
        data_r[CAUSE_ID_LSB +: 5]           = cause_id;
      end
      ADDR_EPC:   data_r = epc;
      ADDR_VBASE: data_r = vbase;
      ADDR_MODE:  data_r[N_IRQ-1:0] = mode;
      default:    data_r = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_irq_ctrl.sv
// Bench for cp0_irq_ctrl: directed scenarios plus randomized edge-interrupt trials
// checked against an event-level pending/priority model.
module tb_cp0_irq_ctrl;

  localparam logic [4:0] A_STATUS = 5'd12;
  localparam logic [4:0] A_CAUSE  = 5'd13;
  localparam logic [4:0] A_EPC    = 5'd14;
  localparam logic [4:0] A_VBASE  = 5'd15;
  localparam logic [4:0] A_MODE   = 5'd16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  oper = 2'b00;
  logic [4:0]  addr_r = '0, addr_w = '0;
  logic [31:0] data_r, data_w = '0;
  logic [3:0]  ir_in = '0;
  logic        ir_en = 1'b1;
  logic [31:0] ret_addr = '0;
  logic        jump_en;
  logic [31:0] jump_addr;
  logic        irq_busy;

  int   n_checks = 0;
  int   n_fail   = 0;
  bit   stall    = 1'b0;
  logic [3:0] model_pend;

  cp0_irq_ctrl dut (
    .clk(clk), .rst(rst), .oper(oper), .addr_r(addr_r), .data_r(data_r),
    .addr_w(addr_w), .data_w(data_w), .ir_in(ir_in), .ir_en(ir_en),
    .ret_addr(ret_addr), .jump_en(jump_en), .jump_addr(jump_addr), .irq_busy(irq_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    addr_r = a;
    #1;
    d = data_r;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    oper = 2'b10; addr_w = a; data_w = d;
    tick();
    oper = 2'b00;
  endtask

  function automatic int lowest(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic wait_jump(output bit seen);
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      ir_en = stall ? 1'($urandom % 2) : 1'b1;
      tick();
      if (jump_en) seen = 1'b1;
    end
    ir_en = 1'b1;
  endtask

  // Called while in SERVICE.
  task automatic do_eret(input logic [31:0] exp_ret);
    oper = 2'b11;
    tick();
    oper = 2'b00;
    chk("eret_jump_en", 32'(jump_en), 32'd1);
    chk("eret_jump_addr", jump_addr, exp_ret);
    tick();
    chk("eret_pulse_one", 32'(jump_en), 32'd0);
    chk("eret_busy_clr", 32'(irq_busy), 32'd0);
  endtask

  task automatic drain(input logic [3:0] im_eff, input logic [31:0] vb);
    logic [31:0] d, r;
    bit seen;
    int ch;
    for (int e = 0; e < 5 && (model_pend & im_eff) != 0; e++) begin
      ch = lowest(model_pend & im_eff);
      r = $urandom & 32'hFFFF_FFFC;
      ret_addr = r;
      wait_jump(seen);
      chk("jump_seen", 32'(seen), 32'd1);
      if (!seen) return;
      chk("vec_addr", jump_addr, vb + 32'(ch) * 32'd8);
      chk("busy_on_entry", 32'(irq_busy), 32'd1);
      model_pend[ch] = 1'b0;
      rd(A_CAUSE, d);
      chk("ip_after_take", 32'(d[11:8]), 32'(model_pend));
      chk("cause_id", 32'(d[6:2]), 32'(ch));
      rd(A_EPC, d);
      chk("epc", d, r);
      tick();
      chk("jump_pulse_one", 32'(jump_en), 32'd0);
      do_eret(r);
    end
  endtask

  task automatic run_trial(input logic [3:0] pulses, input logic [3:0] im,
                           input logic [31:0] vb);
    logic [31:0] d;
    logic        any;
    mtc0(A_VBASE, vb);
    mtc0(A_STATUS, (32'(im) << 8) | 32'h1);
    ir_in = pulses;
    tick();
    ir_in = '0;
    tick();
    rd(A_CAUSE, d);
    chk("ip_not_yet", 32'(d[11:8]), 32'd0);
    tick();
    rd(A_CAUSE, d);
    chk("ip_latency", 32'(d[11:8]), 32'(pulses));
    model_pend = pulses;
    drain(im, vb);
    any = 1'b0;
    repeat (6) begin
      tick();
      any |= jump_en;
    end
    chk("masked_no_jump", 32'(any), 32'd0);
    rd(A_CAUSE, d);
    chk("ip_masked_left", 32'(d[11:8]), 32'(model_pend));
    if (model_pend != 0) begin
      mtc0(A_STATUS, 32'h0000_0F01);
      drain(4'hF, vb);
    end
  endtask

  initial begin
    logic [31:0] d;
    logic        any;
    bit          seen;

    // Reset and register-file behaviour.
    repeat (2) tick();
    @(negedge clk) rst = 1'b1;
    tick();
    chk("rst_jump_en", 32'(jump_en), 32'd0);
    chk("rst_busy", 32'(irq_busy), 32'd0);
    rd(A_VBASE, d); chk("rst_vbase", d, 32'h10);
    mtc0(A_VBASE, 32'h123);
    rd(A_VBASE, d); chk("vbase_align", d, 32'h120);
    mtc0(A_STATUS, 32'h3);
    rd(A_STATUS, d); chk("exl_readonly", d, 32'h1);
    mtc0(A_EPC, 32'h55);
    rd(A_EPC, d); chk("epc_write", d, 32'h55);
    mtc0(5'd20, 32'hFFFF_FFFF);
    rd(5'd20, d); chk("unlisted_zero", d, 32'h0);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    rd(A_STATUS, d); chk("arst_status", d, 32'h0);
    rd(A_VBASE, d);  chk("arst_vbase", d, 32'h10);
    rd(A_EPC, d);    chk("arst_epc", d, 32'h0);
    rd(A_CAUSE, d);  chk("arst_cause", d, 32'h0);
    chk("arst_jump_addr", jump_addr, 32'h0);
    @(negedge clk) rst = 1'b1;
    tick();

    // Single edge on channel 2, then channels 1 and 3 together.
    stall = 1'b0;
    run_trial(4'b0100, 4'hF, 32'h10);
    run_trial(4'b1010, 4'hF, 32'h10);

    // Masked channel 0, then unmask while the pipeline refuses redirects.
    ret_addr = 32'h200;
    mtc0(A_STATUS, 32'h1);
    ir_in = 4'b0001;
    tick();
    ir_in = '0;
    any = 1'b0;
    repeat (6) begin
      tick();
      any |= jump_en;
    end
    chk("mask_no_jump", 32'(any), 32'd0);
    rd(A_CAUSE, d); chk("mask_ip0", 32'(d[11:8]), 32'h1);
    ir_en = 1'b0;
    mtc0(A_STATUS, 32'hF01);
    any = 1'b0;
    repeat (5) begin
      tick();
      any |= jump_en;
    end
    chk("stall_no_jump", 32'(any), 32'd0);
    ir_en = 1'b1;
    tick();
    chk("stall_release_jump", 32'(jump_en), 32'd1);
    chk("ch0_vec", jump_addr, 32'h10);
    tick();
    do_eret(32'h200);

    // Level mode on channel 1.
    mtc0(A_MODE, 32'h2);
    ret_addr = 32'h300;
    ir_in = 4'b0010;
    wait_jump(seen);
    chk("lvl_jump_seen", 32'(seen), 32'd1);
    chk("lvl_vec", jump_addr, 32'h18);
    tick();
    rd(A_CAUSE, d); chk("lvl_ip_held", 32'(d[11:8]), 32'h2);
    ir_in = '0;
    repeat (5) tick();
    rd(A_CAUSE, d); chk("lvl_ip_released", 32'(d[11:8]), 32'h0);
    do_eret(32'h300);
    any = 1'b0;
    repeat (10) begin
      tick();
      any |= jump_en;
    end
    chk("lvl_no_reentry", 32'(any), 32'd0);
    mtc0(A_MODE, 32'h0);

    // Randomized edge trials against the pending/priority model.
    stall = 1'b1;
    for (int t = 0; t < 12; t++) begin
      run_trial(4'($urandom_range(1, 15)), 4'($urandom % 16),
                ($urandom & 32'h0000_FFFF) & 32'hFFFF_FFFC);
    end
    stall = 1'b0;

    // Reset while servicing: no return jump afterwards.
    mtc0(A_STATUS, 32'hF01);
    ir_in = 4'b0001;
    tick();
    ir_in = '0;
    wait_jump(seen);
    chk("svc_jump_seen", 32'(seen), 32'd1);
    tick();
    chk("svc_busy", 32'(irq_busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("svc_rst_busy", 32'(irq_busy), 32'd0);
    chk("svc_rst_jump_en", 32'(jump_en), 32'd0);
    rd(A_STATUS, d); chk("svc_rst_status", d, 32'h0);
    @(negedge clk) rst = 1'b1;
    tick();
    oper = 2'b11;
    tick();
    oper = 2'b00;
    any = jump_en;
    repeat (5) begin
      tick();
      any |= jump_en;
    end
    chk("svc_rst_no_eret_jump", 32'(any), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
